// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-way traffic-light controller.
// Lamp vectors are one-hot {red, yellow, green}.
package traffic_pkg;

    localparam int unsigned LAMP_W   = 3;
    localparam int unsigned REMAIN_W = 4;
    localparam int unsigned DUR_MAX  = 15;

    localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_ALLRED_A  = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_ALLRED_B  = 3'd5
    } state_e;

    typedef struct packed {
        logic [LAMP_W-1:0] ns;
        logic [LAMP_W-1:0] ew;
    } lamps_t;

    // Lamp pattern shown while sitting in a given state.
    function automatic lamps_t state_lamps(state_e s);
        lamps_t l;
        l.ns = LAMP_R;
        l.ew = LAMP_R;
        case (s)
            ST_NS_GREEN:  l.ns = LAMP_G;
            ST_NS_YELLOW: l.ns = LAMP_Y;
            ST_EW_GREEN:  l.ew = LAMP_G;
            ST_EW_YELLOW: l.ew = LAMP_Y;
            default:      ;
        endcase
        return l;
    endfunction

    function automatic logic is_green(state_e s);
        return (s == ST_NS_GREEN) || (s == ST_EW_GREEN);
    endfunction

    function automatic logic is_yellow(state_e s);
        return (s == ST_NS_YELLOW) || (s == ST_EW_YELLOW);
    endfunction

endpackage

// File: rtl/rise_tick.sv
// Rising-edge detector: registers a clk-synchronous level and emits a
// one-cycle pulse on each 0->1 transition.
module rise_tick (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic tick_c
);

    logic sig_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign tick_c = sig & ~sig_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Six-phase two-way traffic-light controller paced by div_clk rising edges,
// with pedestrian-request green shortening and a per-phase countdown.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_SEC  = 5,
    parameter int unsigned YELLOW_SEC = 2,
    parameter int unsigned ALLRED_SEC = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                div_clk,
    input  logic                ped_req,
    output logic                ped_ack,
    output logic [LAMP_W-1:0]   ns_light,
    output logic [LAMP_W-1:0]   ew_light,
    output logic [REMAIN_W-1:0] remain
);

    // Durations must fit the 4-bit countdown and be non-zero.
    if (GREEN_SEC == 0 || GREEN_SEC > DUR_MAX ||
        YELLOW_SEC == 0 || YELLOW_SEC > DUR_MAX ||
        ALLRED_SEC == 0 || ALLRED_SEC > DUR_MAX) begin : g_bad_duration
        $error("traffic_light_ctrl: phase durations must be in 1..15");
    end

    localparam logic [REMAIN_W-1:0] GREEN_DUR  = REMAIN_W'(GREEN_SEC);
    localparam logic [REMAIN_W-1:0] YELLOW_DUR = REMAIN_W'(YELLOW_SEC);
    localparam logic [REMAIN_W-1:0] ALLRED_DUR = REMAIN_W'(ALLRED_SEC);

    state_e              state_q;
    state_e              state_d;
    state_e              next_st;
    logic [REMAIN_W-1:0] next_dur;
    logic [REMAIN_W-1:0] remain_d;
    logic                ped_pend_q;
    logic                ped_pend_d;
    logic                ped_ack_d;
    lamps_t              lamps_d;
    logic                tick_c;

    rise_tick u_rise_tick (
        .clk    (clk),
        .reset  (reset),
        .sig    (div_clk),
        .tick_c (tick_c)
    );

    // Next-state / countdown / pedestrian bookkeeping.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain;
        ped_pend_d = ped_pend_q | ped_req;
        ped_ack_d  = 1'b0;
        next_st    = ST_NS_GREEN;
        next_dur   = GREEN_DUR;

        case (state_q)
            ST_NS_GREEN: begin
                next_st  = ST_NS_YELLOW;
                next_dur = YELLOW_DUR;
            end
            ST_NS_YELLOW: begin
                next_st  = ST_ALLRED_A;
                next_dur = ALLRED_DUR;
            end
            ST_ALLRED_A: begin
                next_st  = ST_EW_GREEN;
                next_dur = GREEN_DUR;
            end
            ST_EW_GREEN: begin
                next_st  = ST_EW_YELLOW;
                next_dur = YELLOW_DUR;
            end
            ST_EW_YELLOW: begin
                next_st  = ST_ALLRED_B;
                next_dur = ALLRED_DUR;
            end
            default: begin
                next_st  = ST_NS_GREEN;
                next_dur = GREEN_DUR;
            end
        endcase

        if (tick_c) begin
            if (remain == REMAIN_W'(1)) begin
                state_d  = next_st;
                remain_d = next_dur;
                // Entering yellow drops any request, including one arriving now.
                if (is_yellow(next_st)) begin
                    ped_pend_d = 1'b0;
                end
            end else if (is_green(state_q) && ped_pend_q && remain > REMAIN_W'(2)) begin
                remain_d  = REMAIN_W'(1);
                ped_ack_d = 1'b1;
            end else begin
                remain_d = remain - REMAIN_W'(1);
            end
        end

        lamps_d = state_lamps(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_NS_GREEN;
            remain     <= GREEN_DUR;
            ped_pend_q <= 1'b0;
            ped_ack    <= 1'b0;
            ns_light   <= LAMP_G;
            ew_light   <= LAMP_R;
        end else begin
            state_q    <= state_d;
            remain     <= remain_d;
            ped_pend_q <= ped_pend_d;
            ped_ack    <= ped_ack_d;
            ns_light   <= lamps_d.ns;
            ew_light   <= lamps_d.ew;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: default-parameter DUT plus an all-ones
// duration DUT sharing the same stimulus, both checked against a phase model.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       div_clk = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [3:0] remain;
    logic       sw_ack;
    logic [2:0] sw_ns;
    logic [2:0] sw_ew;
    logic [3:0] sw_remain;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    int sw_ack_cnt = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl u_dut (
        .clk      (clk),
        .reset    (reset),
        .div_clk  (div_clk),
        .ped_req  (ped_req),
        .ped_ack  (ped_ack),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .remain   (remain)
    );

    traffic_light_ctrl #(
        .GREEN_SEC  (1),
        .YELLOW_SEC (1),
        .ALLRED_SEC (1)
    ) u_sweep (
        .clk      (clk),
        .reset    (reset),
        .div_clk  (div_clk),
        .ped_req  (ped_req),
        .ped_ack  (sw_ack),
        .ns_light (sw_ns),
        .ew_light (sw_ew),
        .remain   (sw_remain)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Phase model: phase index 0..5 walks NS_G, NS_Y, AR_A, EW_G, EW_Y, AR_B.
    typedef struct {
        int ph;
        int rem;
        bit pend;
        bit ack;
    } mdl_t;

    int ns_tab[6] = '{1, 2, 4, 4, 4, 4};
    int ew_tab[6] = '{4, 4, 4, 1, 2, 4};

    function automatic mdl_t mreset(input int g);
        mdl_t m;
        m.ph = 0;
        m.rem = g;
        m.pend = 1'b0;
        m.ack = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit tk, input bit req,
                                   input int g, input int y, input int a);
        mdl_t n;
        int d[6];
        d = '{g, y, a, g, y, a};
        n = m;
        n.ack = 1'b0;
        n.pend = m.pend | req;
        if (tk) begin
            if (m.rem == 1) begin
                n.ph = (m.ph + 1) % 6;
                n.rem = d[n.ph];
                if (n.ph == 1 || n.ph == 4) n.pend = 1'b0;
            end else if ((m.ph == 0 || m.ph == 3) && m.pend && m.rem > 2) begin
                n.rem = 1;
                n.ack = 1'b1;
            end else begin
                n.rem = m.rem - 1;
            end
        end
        return n;
    endfunction

    mdl_t m_def = '{ph: 0, rem: 5, pend: 1'b0, ack: 1'b0};
    mdl_t m_sw  = '{ph: 0, rem: 1, pend: 1'b0, ack: 1'b0};
    bit   div_prev = 1'b0;

    always @(posedge clk or negedge reset) begin
        bit tk;
        if (!reset) begin
            div_prev = 1'b0;
            m_def = mreset(5);
            m_sw = mreset(1);
        end else begin
            tk = div_clk && !div_prev;
            m_def = mstep(m_def, tk, ped_req, 5, 2, 1);
            m_sw = mstep(m_sw, tk, ped_req, 1, 1, 1);
            div_prev = div_clk;
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        chk("def_ns", ns_light, ns_tab[m_def.ph]);
        chk("def_ew", ew_light, ew_tab[m_def.ph]);
        chk("def_remain", remain, m_def.rem);
        chk("def_ack", ped_ack, m_def.ack);
        chk("sw_ns", sw_ns, ns_tab[m_sw.ph]);
        chk("sw_ew", sw_ew, ew_tab[m_sw.ph]);
        chk("sw_remain", sw_remain, m_sw.rem);
        chk("sw_ack", sw_ack, m_sw.ack);
    end

    always @(negedge clk) begin
        if (ped_ack) ack_cnt++;
        if (sw_ack) sw_ack_cnt++;
    end

    // Called at a falling clk edge; returns at a falling edge after the tick landed.
    task automatic do_tick(input bit req);
        div_clk = 1'b1;
        ped_req = req;
        @(negedge clk);
        ped_req = 1'b0;
        @(negedge clk);
        div_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_req();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        @(negedge clk);
    endtask

    int exp_rem[16] = '{4, 3, 2, 1, 2, 1, 1, 5, 4, 3, 2, 1, 2, 1, 1, 5};
    int a0;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ns", ns_light, 1);
        chk("rst_ew", ew_light, 4);
        chk("rst_remain", remain, 5);
        chk("rst_ack", ped_ack, 0);
        chk("rst_sw_remain", sw_remain, 1);
        reset = 1'b1;
        @(negedge clk);

        // Constant high div_clk gives a single tick
        div_clk = 1'b1;
        repeat (100) @(negedge clk);
        chk("hold_remain", remain, 4);
        chk("hold_sw_ns", sw_ns, 2);
        div_clk = 1'b0;
        repeat (2) @(negedge clk);

        // Full cycle from a fresh reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            do_tick(1'b0);
            chk("cycle_remain", remain, exp_rem[i]);
            if (i == 5) begin
                chk("sw_six_ns", sw_ns, 1);
                chk("sw_six_ew", sw_ew, 4);
            end
            if (i == 7) begin
                chk("ewg_ns", ns_light, 4);
                chk("ewg_ew", ew_light, 1);
            end
        end
        chk("cycle_end_ns", ns_light, 1);
        chk("sw_cycle_ns", sw_ns, 4);
        chk("sw_cycle_ew", sw_ew, 2);

        // Pedestrian served in NS green at remain=4
        do_tick(1'b0);
        chk("ped_pre_remain", remain, 4);
        pulse_req();
        a0 = ack_cnt;
        do_tick(1'b0);
        chk("ped_served_remain", remain, 1);
        chk("ped_served_acks", ack_cnt - a0, 1);
        do_tick(1'b0);
        chk("ped_yellow_remain", remain, 2);
        chk("ped_yellow_ns", ns_light, 2);

        // Request during yellow held until EW green
        pulse_req();
        a0 = ack_cnt;
        do_tick(1'b0);
        do_tick(1'b0);
        chk("held_allred_ns", ns_light, 4);
        chk("held_allred_ew", ew_light, 4);
        do_tick(1'b0);
        chk("held_ewg_remain", remain, 5);
        chk("held_no_ack_yet", ack_cnt - a0, 0);
        do_tick(1'b0);
        chk("held_served_remain", remain, 1);
        chk("held_served_acks", ack_cnt - a0, 1);

        // Asynchronous reset in EW yellow with a request pending
        do_tick(1'b0);
        chk("ewy_ew", ew_light, 2);
        pulse_req();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_ns", ns_light, 1);
        chk("async_ew", ew_light, 4);
        chk("async_remain", remain, 5);
        chk("async_ack", ped_ack, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        a0 = ack_cnt;
        repeat (3) do_tick(1'b0);
        chk("post_rst_remain", remain, 2);
        chk("post_rst_acks", ack_cnt - a0, 0);

        // Request at remain<=2 and request coinciding with entry to yellow
        pulse_req();
        do_tick(1'b0);
        chk("late_req_remain", remain, 1);
        do_tick(1'b1);
        chk("coinc_yellow_remain", remain, 2);
        do_tick(1'b0);
        do_tick(1'b0);
        do_tick(1'b0);
        do_tick(1'b0);
        chk("coinc_ewg_remain", remain, 4);
        chk("late_req_acks", ack_cnt - a0, 0);
        chk("sw_never_ack", sw_ack_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
